wb_arbiter2: RTL

Two-master, single-slave Wishbone classic arbiter that shares the memory port (`mem_wishbone`) between `xm_cpu` and a second bus master such as a DMA or debug loader. It provides round-robin fairness and holds a grant for the master's whole `cyc` tenure. A bus watchdog terminates unacknowledged strobes with an error so a missing slave cannot hang either master. It sits between the masters and the memory in the top level, replacing the direct CPU–memory connection.

---
 rtl/wb_arb_pkg.sv | 13 +
 rtl/wb_watchdog.sv | 28 ++
 rtl/wb_arbiter2.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: flags a strobe that has waited TIMEOUT cycles without ack.
module wb_watchdog #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic stb,
    input  logic ack,
    input  logic clr,
    output logic timeout
);

    localparam int unsigned WD_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd;

    // Ack in the same cycle as the limit wins; TIMEOUT of 0 disables the check.
    assign timeout = (TIMEOUT != 0) && (wd == WD_W'(TIMEOUT)) && !ack;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr || timeout || !stb || ack) begin
            wd <= '0;
        end else if (TIMEOUT != 0) begin
            wd <= wd + WD_W'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// Round-robin arbiter sharing one Wishbone classic slave between two masters,
// with a watchdog that errors out strobes the slave never acknowledges.
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [SEL_W-1:0]  m0_sel_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DATA_W-1:0] m0_dat_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [SEL_W-1:0]  m1_sel_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [SEL_W-1:0]  s_sel_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic              s_ack_i,
    input  logic [DATA_W-1:0] s_dat_i,
    output logic [1:0]        gnt_o
);

    arb_state_t        state;
    logic              last;
    logic [1:0]        gnt;
    logic              g_cyc;
    logic              g_stb;
    logic              g_we;
    logic [SEL_W-1:0]  g_sel;
    logic [ADDR_W-1:0] g_adr;
    logic [DATA_W-1:0] g_dat;
    logic              wd_clr;
    logic              timeout;

    // Request mux from the granted master; everything stays 0 while idle.
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_sel = '0;
        g_adr = '0;
        g_dat = '0;
        case (state)
            GNT0: begin
                g_cyc = m0_cyc_i;
                g_stb = m0_stb_i;
                g_we  = m0_we_i;
                g_sel = m0_sel_i;
                g_adr = m0_adr_i;
                g_dat = m0_dat_i;
            end
            GNT1: begin
                g_cyc = m1_cyc_i;
                g_stb = m1_stb_i;
                g_we  = m1_we_i;
                g_sel = m1_sel_i;
                g_adr = m1_adr_i;
                g_dat = m1_dat_i;
            end
            default: ;
        endcase
    end

    // The state can only change when the granted cyc is low, so that also clears the watchdog.
    assign wd_clr = ~g_cyc;

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stb     (g_stb),
        .ack     (s_ack_i),
        .clr     (wd_clr),
        .timeout (timeout)
    );

    // Grant FSM; ties in IDLE go to the master that was not granted last.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= M1;
            gnt   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last == M1)) begin
                        state <= GNT0;
                        last  <= M0;
                        gnt   <= 2'b01;
                    end else if (m1_cyc_i) begin
                        state <= GNT1;
                        last  <= M1;
                        gnt   <= 2'b10;
                    end
                end
                GNT0: begin
                    if (!m0_cyc_i) begin
                        if (m1_cyc_i) begin
                            state <= GNT1;
                            last  <= M1;
                            gnt   <= 2'b10;
                        end else begin
                            state <= IDLE;
                            gnt   <= 2'b00;
                        end
                    end
                end
                GNT1: begin
                    if (!m1_cyc_i) begin
                        if (m0_cyc_i) begin
                            state <= GNT0;
                            last  <= M0;
                            gnt   <= 2'b01;
                        end else begin
                            state <= IDLE;
                            gnt   <= 2'b00;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                end
            endcase
        end
    end

    assign s_cyc_o = g_cyc;
    assign s_stb_o = g_stb & ~timeout;
    assign s_we_o  = g_we;
    assign s_sel_o = g_sel;
    assign s_adr_o = g_adr;
    assign s_dat_o = g_dat;
    assign gnt_o   = gnt;

    // Responses reach only the granted master, and never during reset.
    assign m0_ack_o = s_ack_i & (state == GNT0) & ~rst_i;
    assign m1_ack_o = s_ack_i & (state == GNT1) & ~rst_i;
    assign m0_err_o = timeout & (state == GNT0) & ~rst_i;
    assign m1_err_o = timeout & (state == GNT1) & ~rst_i;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule
